// File: rtl/div32_seq.sv
// Sequential 32-bit restoring divider for DIV/DIVU: one quotient bit per cycle
// on operand magnitudes, followed by a sign fix-up cycle; quotient -> LO, remainder -> HI.
module div32_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIX,
    ST_DONE
  } state_t;

  state_t state, state_nxt;

  // Partial remainder kept in 32 bits: after every step it is below the divisor.
  logic [31:0] p_reg;
  logic [31:0] q_reg;
  logic [31:0] dvs_reg;
  logic [31:0] raw_dvd;
  logic [4:0]  step;
  logic        sign_q;
  logic        sign_r;
  logic        dbz_reg;

  logic [31:0] dvd_mag;
  logic [31:0] dvs_mag;
  logic [32:0] shifted;
  logic [31:0] trial;
  logic        take;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  // Operand magnitudes at acceptance
  always_comb begin
    dvd_mag = dividend;
    dvs_mag = divisor;
    if (is_signed && dividend[31]) dvd_mag = -dividend;
    if (is_signed && divisor[31])  dvs_mag = -divisor;
  end

  // One restoring step: shifted P versus divisor; subtraction only valid when it fits
  always_comb begin
    shifted = {p_reg, q_reg[31]};
    take    = (shifted >= {1'b0, dvs_reg});
    trial   = shifted[31:0] - dvs_reg;
  end

  always_comb begin
    q_fix = sign_q ? -q_reg : q_reg;
    r_fix = sign_r ? -p_reg : p_reg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (step == 5'd31) state_nxt = ST_FIX;
      end
      ST_FIX: begin
        busy      = 1'b1;
        state_nxt = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_reg       <= '0;
      q_reg       <= '0;
      dvs_reg     <= '0;
      raw_dvd     <= '0;
      step        <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      dbz_reg     <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            p_reg   <= '0;
            q_reg   <= dvd_mag;
            dvs_reg <= dvs_mag;
            raw_dvd <= dividend;
            step    <= '0;
            sign_q  <= is_signed & (dividend[31] ^ divisor[31]);
            sign_r  <= is_signed & dividend[31];
            dbz_reg <= (divisor == '0);
          end
        end
        ST_RUN: begin
          p_reg <= take ? trial : shifted[31:0];
          q_reg <= {q_reg[30:0], take};
          step  <= step + 5'd1;
        end
        ST_FIX: begin
          if (dbz_reg) begin
            quotient  <= '1;
            remainder <= raw_dvd;
          end else begin
            quotient  <= q_fix;
            remainder <= r_fix;
          end
          div_by_zero <= dbz_reg;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div32_seq.sv
// Scoreboard bench for div32_seq: directed cases with literal expectations,
// then randomized back-to-back operations checked against plain arithmetic.
module tb_div32_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
  } exp_t;

  exp_t exp_q[$];

  div32_seq dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .is_signed  (is_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Truncating division, remainder takes the dividend's sign; /0 gives all-ones and the dividend
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t   e;
    longint sa, sb, lq, lr;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF;
      e.r = a;
      e.z = 1'b1;
    end else if (s) begin
      sa  = $signed(a);
      sb  = $signed(b);
      lq  = sa / sb;
      lr  = sa % sb;
      e.q = lq[31:0];
      e.r = lr[31:0];
      e.z = 1'b0;
    end else begin
      e.q = a / b;
      e.r = a % b;
      e.z = 1'b0;
    end
    return e;
  endfunction

  // Monitor: every done pulse consumes one expected result
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.z});
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  // Leaves the bench at #1 after the accepting edge with start low again
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input bit push, input exp_t e);
    wait_idle();
    dividend  = a;
    divisor   = b;
    is_signed = s;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    dividend  = $urandom;
    divisor   = $urandom;
    is_signed = $urandom_range(0, 1);
    if (push) exp_q.push_back(e);
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 60) chk("done_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
  endtask

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    exp_t        e;
  } dcase_t;

  dcase_t dir[7];

  initial begin
    dir[0] = '{32'hFFFF_FFF9, 32'd2,        1'b1, '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0}};
    dir[1] = '{32'd7,        32'hFFFF_FFFE, 1'b1, '{32'hFFFF_FFFD, 32'd1,        1'b0}};
    dir[2] = '{32'hFFFF_FFFF, 32'd1,        1'b0, '{32'hFFFF_FFFF, 32'd0,        1'b0}};
    dir[3] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, '{32'h8000_0000, 32'd0,        1'b0}};
    dir[4] = '{32'd5,        32'd0,        1'b1, '{32'hFFFF_FFFF, 32'd5,        1'b1}};
    dir[5] = '{32'd5,        32'd0,        1'b0, '{32'hFFFF_FFFF, 32'd5,        1'b1}};
    dir[6] = '{32'd9,        32'd3,        1'b0, '{32'd3,         32'd0,        1'b0}};
  end

  initial begin
    int   first_done;
    bit   busy_ok;
    bit   saw_done;
    exp_t e100 = '{32'd14, 32'd2, 1'b0};

    reset = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", remainder, 32'd0);
    chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // 100 / 7 with cycle-exact busy/done profile: edges E0..E34
    issue(32'd100, 32'd7, 1'b0, 1'b1, e100);
    busy_ok    = (busy === 1'b1) && (done === 1'b0);
    first_done = -1;
    for (int k = 1; k <= 33; k++) begin
      @(posedge clk); #1;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1 && first_done < 0) first_done = k;
    end
    chk("busy_high_e0_e33", {31'd0, busy_ok}, 32'd1);
    chk("done_edge", first_done, 32'd33);
    @(posedge clk); #1;
    chk("busy_low_after_e34", {31'd0, busy}, 32'd0);
    chk("done_low_after_e34", {31'd0, done}, 32'd0);

    foreach (dir[i]) begin
      issue(dir[i].a, dir[i].b, dir[i].s, 1'b1, dir[i].e);
      wait_done();
    end

    // start pulse during RUN must be ignored
    issue(32'd100, 32'd7, 1'b0, 1'b1, e100);
    repeat (9) begin @(posedge clk); #1; end
    dividend = 32'd50; divisor = 32'd3; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();
    repeat (40) begin @(posedge clk); #1; end

    // reset mid-operation discards the result
    issue(32'd12345, 32'd17, 1'b0, 1'b0, '0);
    repeat (20) begin @(posedge clk); #1; end
    reset = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_quotient", quotient, 32'd0);
    chk("midrst_remainder", remainder, 32'd0);
    chk("midrst_dbz", {31'd0, div_by_zero}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    chk("no_done_after_reset", {31'd0, saw_done}, 32'd0);
    issue(32'hFFFF_FFF7, 32'd3, 1'b1, 1'b1, '{32'hFFFF_FFFD, 32'd0, 1'b0});
    wait_done();

    // randomized back-to-back traffic
    for (int n = 0; n < 200; n++) begin
      logic [31:0] a, b;
      logic        s;
      a = $urandom;
      b = $urandom;
      s = $urandom_range(0, 1);
      case ($urandom_range(0, 6))
        0: b = 32'd0;
        1: b = $urandom_range(1, 16);
        2: b = -$urandom_range(1, 16);
        3: a = 32'h8000_0000;
        4: b = a >> $urandom_range(0, 31);
        5: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      issue(a, b, s, 1'b1, model(a, b, s));
      wait_done();
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
